// File: rtl/gfx_pkg.sv
// Shared display-path definitions: VGA 640x480@60 timing constants,
// default pixel width, RGB444 pixel layout and the scanout state type.
package gfx_pkg;

  localparam int GFX_DATA_WIDTH = 12;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP
                              + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP
                              + VGA_V_SYNC + VGA_V_BP;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef enum logic {
    SCAN_IDLE = 1'b0,
    SCAN_RUN  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/vga_timing_gen.sv
// Raster position counters plus active/sync/origin decode; the counters
// are parked at (0,0) while hold is high.
module vga_timing_gen
  import gfx_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int HCW      = 10,
  parameter int VCW      = 10
) (
  input  logic clk,
  input  logic rst_,
  input  logic hold,
  output logic active,
  output logic hsync_on,
  output logic vsync_on,
  output logic origin
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HCW-1:0] H_LAST  = HCW'(H_TOTAL - 1);
  localparam logic [VCW-1:0] V_LAST  = VCW'(V_TOTAL - 1);
  localparam logic [HCW-1:0] H_ACT   = HCW'(H_ACTIVE);
  localparam logic [VCW-1:0] V_ACT   = VCW'(V_ACTIVE);
  localparam logic [HCW-1:0] HS_LO   = HCW'(H_ACTIVE + H_FP);
  localparam logic [HCW-1:0] HS_HI   = HCW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VCW-1:0] VS_LO   = VCW'(V_ACTIVE + V_FP);
  localparam logic [VCW-1:0] VS_HI   = VCW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HCW-1:0] h_cnt_q, h_cnt_d;
  logic [VCW-1:0] v_cnt_q, v_cnt_d;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (hold) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0
              : v_cnt_q + VCW'(1);
    end else begin
      h_cnt_d = h_cnt_q + HCW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign active   = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign hsync_on = (h_cnt_q >= HS_LO) && (h_cnt_q < HS_HI);
  assign vsync_on = (v_cnt_q >= VS_LO) && (v_cnt_q < VS_HI);
  assign origin   = (h_cnt_q == '0) && (v_cnt_q == '0);

endmodule

// File: rtl/fifo_vga_scanout.sv
// Drains the pixel FIFO one word per active pixel and drives VGA timing.
// SCANOUT_UNDERFLOW_CNT_EN adds a saturating starved-pixel counter.
module fifo_vga_scanout
  import gfx_pkg::*;
#(
  parameter int DATA_WIDTH = GFX_DATA_WIDTH,
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter int HCW        = 10,
  parameter int VCW        = 10
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_rts,
  output logic                  in_rtr,
  output logic [DATA_WIDTH-1:0] rgb,
  output logic                  hsync_,
  output logic                  vsync_,
  output logic                  de,
  output logic                  frame_start,
`ifdef SCANOUT_UNDERFLOW_CNT_EN
  output logic [15:0]           underflow_cnt,
`endif
  output logic                  underflow
);

  scan_state_e state_q, state_d;

  logic run;
  logic active;
  logic hsync_on;
  logic vsync_on;
  logic origin;
  logic xfc;
  logic starve;

  logic [DATA_WIDTH-1:0] rgb_q, rgb_d;
  logic hs_n_q, hs_n_d;
  logic vs_n_q, vs_n_d;
  logic de_q, de_d;
  logic fs_q, fs_d;
  logic uf_q, uf_d;

  assign run    = (state_q == SCAN_RUN);
  assign in_rtr = run & active;
  assign xfc    = in_rts & in_rtr;
  assign starve = in_rtr & ~in_rts;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .HCW      (HCW),
    .VCW      (VCW)
  ) u_timing (
    .clk      (clk),
    .rst_     (rst_),
    .hold     (~run),
    .active   (active),
    .hsync_on (hsync_on),
    .vsync_on (vsync_on),
    .origin   (origin)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SCAN_IDLE: if (in_rts) state_d = SCAN_RUN;
      SCAN_RUN:  state_d = SCAN_RUN;
      default:   state_d = SCAN_IDLE;
    endcase
  end

  // A starved slot outputs black and is not retried.
  always_comb begin
    rgb_d  = xfc ? in_data : '0;
    de_d   = in_rtr;
    hs_n_d = ~(run & hsync_on);
    vs_n_d = ~(run & vsync_on);
    fs_d   = run & origin;
    uf_d   = uf_q | starve;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= SCAN_IDLE;
      rgb_q   <= '0;
      hs_n_q  <= 1'b1;
      vs_n_q  <= 1'b1;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rgb_q   <= rgb_d;
      hs_n_q  <= hs_n_d;
      vs_n_q  <= vs_n_d;
      de_q    <= de_d;
      fs_q    <= fs_d;
      uf_q    <= uf_d;
    end
  end

  assign rgb         = rgb_q;
  assign hsync_      = hs_n_q;
  assign vsync_      = vs_n_q;
  assign de          = de_q;
  assign frame_start = fs_q;
  assign underflow   = uf_q;

`ifdef SCANOUT_UNDERFLOW_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if (starve && (ucnt_q != 16'hFFFF))
      ucnt_d = ucnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) ucnt_q <= '0;
    else       ucnt_q <= ucnt_d;
  end

  assign underflow_cnt = ucnt_q;
`endif

endmodule
